// File: rtl/instr_trace_buf.sv
// Instruction trace capture: builds one record per executed instruction
// (pc, opcode, operand address, observed data) and queues it in a FIFO.
module instr_trace_buf #(
  parameter int DEPTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     trc_en,
  input  logic                     fetch,
  input  logic                     halt,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [12:0]              addr,
  input  logic [7:0]               data,
  input  logic [2:0]               opcode,
  input  logic [12:0]              ir_addr,
  input  logic [12:0]              pc_addr,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [37:0]              trc_rec,
  output logic [$clog2(DEPTH):0]   trc_level,
  output logic [7:0]               drop_cnt,
  output logic                     trc_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [12:0] pc;
    logic [2:0]  op;
    logic [12:0] ir;
    logic [7:0]  data;
    logic        dv;
  } trc_rec_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_PUSH, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          fetch_q, armed, halt_seen;
  trc_rec_t      cur;
  trc_rec_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    drops;
  logic          fetch_fall, fetch_rise, hit;
  logic          open_rec, close_hit, close_miss;
  logic          push, pop, full, accept, drop;

  // armed only after fetch has been seen low, so a fall needs a full 0->1->0
  assign fetch_fall = armed & fetch_q & ~fetch;
  assign fetch_rise = fetch & ~fetch_q;
  assign hit        = (rd | wr) && (addr == cur.ir);

  assign push   = (state == S_PUSH);
  assign pop    = trc_valid & trc_ready;
  assign full   = (level == LW'(DEPTH));
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign trc_valid = (level != '0);
  assign trc_rec   = trc_valid ? mem[rd_ptr] : '0;
  assign trc_level = level;
  assign drop_cnt  = drops;
  assign trc_done  = (state == S_DONE);

  // next-state and record open/close decisions
  always_comb begin
    state_nxt  = state;
    open_rec   = 1'b0;
    close_hit  = 1'b0;
    close_miss = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt) state_nxt = S_DONE;
        else if (trc_en && fetch_fall) begin
          open_rec  = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!trc_en) state_nxt = S_IDLE;
        else if (hit) begin
          close_hit = 1'b1;
          state_nxt = S_PUSH;
        end else if (fetch_rise || halt) begin
          close_miss = 1'b1;
          state_nxt  = S_PUSH;
        end
      end
      S_PUSH: begin
        if (halt_seen || halt) state_nxt = S_DONE;
        else if (trc_en && fetch_fall) begin
          open_rec  = 1'b1;
          state_nxt = S_EXEC;
        end else state_nxt = S_IDLE;
      end
      default: state_nxt = S_DONE;
    endcase
  end

  // FSM state, fetch history and halt tracking
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fetch_q   <= 1'b0;
      armed     <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      fetch_q <= fetch;
      armed   <= armed | ~fetch;
      if (open_rec) halt_seen <= 1'b0;
      else if ((state == S_EXEC || state == S_PUSH) && halt) halt_seen <= 1'b1;
    end
  end

  // open record being assembled
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cur <= '0;
    else if (open_rec) begin
      cur.pc   <= pc_addr - 13'd1;
      cur.op   <= opcode;
      cur.ir   <= ir_addr;
      cur.data <= 8'h00;
      cur.dv   <= 1'b0;
    end else if (close_hit) begin
      cur.data <= data;
      cur.dv   <= 1'b1;
    end else if (close_miss) begin
      cur.data <= 8'h00;
      cur.dv   <= 1'b0;
    end
  end

  // FIFO storage, no reset needed: reads are masked by level
  always_ff @(posedge sys_clk) begin
    if (accept) mem[wr_ptr] <= cur;
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      drops  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      level <= level + LW'(1);
      else if (!accept && pop) level <= level - LW'(1);
      if (drop && drops != 8'hFF) drops <= drops + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_trace_buf.sv
// Randomized instruction stream checked against a record-queue model.
module tb_instr_trace_buf;
  localparam int DEPTH = 8;

  logic        sys_clk, rst_n, trc_en, fetch, halt, rd, wr, trc_ready;
  logic [12:0] addr, ir_addr, pc_addr;
  logic [7:0]  data;
  logic [2:0]  opcode;
  logic        trc_valid, trc_done;
  logic [37:0] trc_rec;
  logic [$clog2(DEPTH):0] trc_level;
  logic [7:0]  drop_cnt;

  int total = 0, passed = 0;
  logic [37:0] mq[$];
  int mdrop = 0;
  bit pend = 0;
  logic [37:0] pend_rec;

  instr_trace_buf #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .trc_en(trc_en), .fetch(fetch), .halt(halt),
    .rd(rd), .wr(wr), .addr(addr), .data(data), .opcode(opcode), .ir_addr(ir_addr),
    .pc_addr(pc_addr), .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_rec(trc_rec),
    .trc_level(trc_level), .drop_cnt(drop_cnt), .trc_done(trc_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  // record as the trace consumer should see it
  function automatic logic [37:0] mk(input logic [12:0] pc, input logic [2:0] op,
                                     input logic [12:0] ir, input logic [7:0] d, input bit dv);
    logic [12:0] p;
    logic [7:0]  dd;
    p  = pc - 13'd1;
    dd = dv ? d : 8'h00;
    return {p, op, ir, dd, dv};
  endfunction

  function automatic void model_push(input logic [37:0] r);
    if (mq.size() < DEPTH) mq.push_back(r);
    else if (mdrop < 255) mdrop++;
  endfunction

  task automatic fetch_phase(input logic [12:0] pc, input logic [2:0] op, input logic [12:0] ir);
    fetch = 1; pc_addr = pc; opcode = op; ir_addr = ir;
    tick();
    if (pend) begin model_push(pend_rec); pend = 0; end
    fetch = 0;
    tick();
    pc_addr = $urandom; opcode = $urandom; ir_addr = ~ir;
  endtask

  // one instruction; acc=1 closes via matching access, else left for next fetch
  task automatic do_instr(input bit acc, input bit pop_push);
    logic [12:0] pc, ir;
    logic [2:0]  op;
    logic [7:0]  d;
    pc = $urandom; ir = $urandom; op = $urandom; d = $urandom;
    fetch_phase(pc, op, ir);
    if (acc) begin
      if ($urandom_range(1, 0) == 1) begin
        rd = 1; addr = ir ^ 13'h1; data = $urandom; tick(); rd = 0;
      end
      repeat ($urandom_range(2, 0)) tick();
      if ($urandom_range(1, 0) == 1) rd = 1; else wr = 1;
      addr = ir; data = d;
      tick();
      rd = 0; wr = 0; data = $urandom;
      if (pop_push && mq.size() > 0) begin
        trc_ready = 1;
        total++;
        if (trc_rec !== mq[0]) $display("FAIL pop_in_push rec: got %h want %h", trc_rec, mq[0]);
        else passed++;
        void'(mq.pop_front());
      end
      model_push(mk(pc, op, ir, d, 1));
      tick();
      trc_ready = 0;
      total++;
      if (trc_level !== ($clog2(DEPTH)+1)'(mq.size()))
        $display("FAIL instr_level: got %0d want %0d", trc_level, mq.size());
      else passed++;
    end else begin
      repeat ($urandom_range(2, 0)) tick();
      pend = 1;
      pend_rec = mk(pc, op, ir, 8'h00, 0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && mq.size() > 0; k++) begin
      total++;
      if (trc_valid !== 1'b1 || trc_rec !== mq[0])
        $display("FAIL drain_head: got v=%b %h want v=1 %h", trc_valid, trc_rec, mq[0]);
      else passed++;
      total++;
      if (trc_level !== ($clog2(DEPTH)+1)'(mq.size()))
        $display("FAIL drain_level: got %0d want %0d", trc_level, mq.size());
      else passed++;
      if ($urandom_range(1, 0) == 1) begin
        trc_ready = 0; tick();
        total++;
        if (trc_rec !== mq[0]) $display("FAIL hold_stable: got %h want %h", trc_rec, mq[0]);
        else passed++;
      end
      trc_ready = 1; tick(); trc_ready = 0;
      void'(mq.pop_front());
    end
    trc_ready = 1; tick(); trc_ready = 0;
    total++;
    if (trc_valid !== 1'b0 || trc_level !== '0)
      $display("FAIL drain_empty: got v=%b lvl=%0d want v=0 lvl=0", trc_valid, trc_level);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 0; trc_en = 1; fetch = 0; halt = 0; rd = 0; wr = 0; trc_ready = 0;
    addr = 0; data = 0; opcode = 0; ir_addr = 0; pc_addr = 0;
    tick(); tick();
    total++;
    if ({trc_valid, trc_rec, trc_level, drop_cnt, trc_done} !== '0)
      $display("FAIL reset_outputs: got v=%b rec=%h lvl=%0d drop=%0d done=%b want all 0",
               trc_valid, trc_rec, trc_level, drop_cnt, trc_done);
    else passed++;
    rst_n = 1;
    tick();
    mq.delete(); mdrop = 0; pend = 0;
  endtask

  task automatic test_basic_lda();
    fetch_phase(13'h003, 3'd5, 13'h01A);
    rd = 1; addr = 13'h01A; data = 8'h3C;
    tick();
    rd = 0; data = 8'h00;
    total++;
    if (trc_valid !== 1'b0) $display("FAIL lda_early: got v=%b want 0", trc_valid);
    else passed++;
    tick();
    total++;
    if (trc_valid !== 1'b1 || trc_rec !== {13'h002, 3'd5, 13'h01A, 8'h3C, 1'b1} || trc_level !== 4'd1)
      $display("FAIL lda_record: got v=%b rec=%h lvl=%0d want v=1 rec=%h lvl=1",
               trc_valid, trc_rec, trc_level, {13'h002, 3'd5, 13'h01A, 8'h3C, 1'b1});
    else passed++;
    mq.push_back({13'h002, 3'd5, 13'h01A, 8'h3C, 1'b1});
    drain();
  endtask

  task automatic test_jmp();
    fetch_phase(13'h010, 3'd7, 13'h055);
    tick();
    pend = 1;
    pend_rec = {13'h00F, 3'd7, 13'h055, 8'h00, 1'b0};
    do_instr(1, 0);
    drain();
  endtask

  task automatic test_access_vs_fetch();
    fetch_phase(13'h100, 3'd2, 13'h040);
    fetch = 1; rd = 1; addr = 13'h040; data = 8'hA5;
    pc_addr = 13'h200; opcode = 3'd3; ir_addr = 13'h041;
    tick();
    rd = 0; data = 8'h00;
    tick();
    fetch = 0;
    tick();
    rd = 1; addr = 13'h041; data = 8'h5A;
    tick();
    rd = 0;
    tick();
    mq.push_back({13'h0FF, 3'd2, 13'h040, 8'hA5, 1'b1});
    mq.push_back({13'h1FF, 3'd3, 13'h041, 8'h5A, 1'b1});
    drain();
  endtask

  task automatic test_random();
    for (int g = 0; g < 4; g++) begin
      int n;
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) do_instr((i == n - 1) ? 1'b1 : 1'($urandom_range(1, 0)), 0);
      drain();
    end
    total++;
    if (drop_cnt !== 8'(mdrop)) $display("FAIL random_drops: got %0d want %0d", drop_cnt, mdrop);
    else passed++;
  endtask

  task automatic test_overflow_and_simul();
    trc_ready = 0;
    for (int i = 0; i < 10; i++) do_instr(1, 0);
    total++;
    if (trc_level !== 4'd8 || drop_cnt !== 8'd2)
      $display("FAIL overflow: got lvl=%0d drop=%0d want lvl=8 drop=2", trc_level, drop_cnt);
    else passed++;
    do_instr(1, 1);
    total++;
    if (trc_level !== 4'd8 || drop_cnt !== 8'd2)
      $display("FAIL full_push_pop: got lvl=%0d drop=%0d want lvl=8 drop=2", trc_level, drop_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_exec();
    fetch_phase(13'h0AA, 3'd1, 13'h0BB);
    rst_n = 0;
    #1;
    total++;
    if ({trc_valid, trc_rec, trc_level, drop_cnt, trc_done} !== '0)
      $display("FAIL async_reset: got v=%b rec=%h lvl=%0d drop=%0d done=%b want all 0",
               trc_valid, trc_rec, trc_level, drop_cnt, trc_done);
    else passed++;
    tick();
    rst_n = 1;
    mq.delete(); mdrop = 0; pend = 0;
    tick();
    rd = 1; addr = 13'h0BB; data = 8'h11;
    tick();
    rd = 0;
    tick(); tick();
    total++;
    if (trc_level !== '0 || trc_valid !== 1'b0)
      $display("FAIL reset_discard: got lvl=%0d v=%b want 0 0", trc_level, trc_valid);
    else passed++;
    do_instr(1, 0);
    drain();
  endtask

  task automatic test_en_low();
    fetch_phase(13'h0C0, 3'd4, 13'h0C8);
    trc_en = 0;
    tick();
    trc_en = 1;
    rd = 1; addr = 13'h0C8; data = 8'h77;
    tick();
    rd = 0;
    tick(); tick();
    total++;
    if (trc_level !== '0) $display("FAIL en_low_discard: got lvl=%0d want 0", trc_level);
    else passed++;
    do_instr(1, 0);
    do_instr(1, 0);
    drain();
  endtask

  task automatic test_halt();
    do_instr(1, 0);
    fetch_phase(13'h300, 3'd0, 13'h7FF);
    tick();
    halt = 1;
    tick();
    halt = 0;
    mq.push_back({13'h2FF, 3'd0, 13'h7FF, 8'h00, 1'b0});
    tick();
    total++;
    if (trc_done !== 1'b1 || trc_level !== 4'd2)
      $display("FAIL halt_close: got done=%b lvl=%0d want done=1 lvl=2", trc_done, trc_level);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      fetch = 1; tick(); fetch = 0; tick();
      rd = 1; addr = ir_addr; tick(); rd = 0; tick();
    end
    total++;
    if (trc_level !== 4'd2) $display("FAIL done_ignores_fetch: got lvl=%0d want 2", trc_level);
    else passed++;
    drain();
    total++;
    if (trc_done !== 1'b1) $display("FAIL done_sticky: got %b want 1", trc_done);
    else passed++;
  endtask

  task automatic test_halt_idle();
    halt = 1;
    tick();
    halt = 0;
    tick();
    total++;
    if (trc_done !== 1'b1 || trc_level !== '0)
      $display("FAIL halt_idle: got done=%b lvl=%0d want done=1 lvl=0", trc_done, trc_level);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_lda();
    test_jmp();
    test_access_vs_fetch();
    test_random();
    test_en_low();
    test_overflow_and_simul();
    drain();
    test_reset_mid_exec();
    test_halt();
    test_reset();
    test_halt_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
